conv_seq: RTL and testbench

CONV_SEQ -- requirements
Module: conv_seq

---
 rtl/conv_pkg.sv | 44 ++++
 rtl/conv_addr_gen.sv | 33 +++
 rtl/conv_seq.sv | 119 +++++++++++
 tb/tb_conv_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 smoothing sequencer: FSM encoding, kernel
// shift amounts, default image size and window-index helpers.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    ACC  = 3'd2,
    WR   = 3'd3,
    BRD  = 3'd4,
    FIN  = 3'd5
  } state_t;

  localparam int HX = 4;
  localparam int OC = 3;
  localparam int QD = 2;

  localparam int DEF_IMG_W = 512;
  localparam int DEF_IMG_H = 512;

  // Corners weigh 1/16, edges 1/8, centre 1/4 of the 3x3 window.
  function automatic logic [2:0] win_shift(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd2, 4'd6, 4'd8: win_shift = 3'(HX);
      4'd4:                   win_shift = 3'(QD);
      default:                win_shift = 3'(OC);
    endcase
  endfunction

  function automatic logic [1:0] win_dy(input logic [3:0] idx);
    if (idx < 4'd3)      win_dy = 2'd0;
    else if (idx < 4'd6) win_dy = 2'd1;
    else                 win_dy = 2'd2;
  endfunction

  function automatic logic [1:0] win_dx(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd3, 4'd6: win_dx = 2'd0;
      4'd1, 4'd4, 4'd7: win_dx = 2'd1;
      default:          win_dx = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Maps the current pixel and window index to an SRAM word address, either a
// source-window tap or the destination pixel.
module conv_addr_gen import conv_pkg::*; #(
  parameter int          IMG_W    = DEF_IMG_W,
  parameter int          YW       = 9,
  parameter logic [19:0] SRC_BASE = 20'h00000,
  parameter logic [19:0] DST_BASE = 20'h40000
) (
  input  logic [$clog2(IMG_W)-1:0] x,
  input  logic [YW-1:0]            y,
  input  logic [3:0]               widx,
  input  logic                     win,
  output logic [19:0]              addr
);

  localparam int XW = $clog2(IMG_W);

  logic [19:0] row;
  logic [19:0] col;

  // Window taps are only requested for interior pixels, so row/col never wrap.
  always_comb begin
    row  = 20'(y);
    col  = 20'(x);
    addr = DST_BASE + (row << XW) + col;
    if (win) begin
      row  = 20'(y) + 20'(win_dy(widx)) - 20'd1;
      col  = 20'(x) + 20'(win_dx(widx)) - 20'd1;
      addr = SRC_BASE + (row << XW) + col;
    end
  end

endmodule

// File: rtl/conv_seq.sv
// Sequencer that streams an image through a 3x3 binomial smoothing kernel
// using a single-port synchronous SRAM; border pixels are written as zero.
module conv_seq import conv_pkg::*; #(
  parameter int          IMG_W    = DEF_IMG_W,
  parameter int          IMG_H    = DEF_IMG_H,
  parameter logic [19:0] SRC_BASE = 20'h00000,
  parameter logic [19:0] DST_BASE = 20'h40000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        sram_csn,
  output logic        sram_wen,
  output logic [19:0] sram_a,
  output logic [15:0] sram_din,
  input  logic [15:0] sram_dout
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  state_t        state, state_nx;
  logic [XW-1:0] x, x_nx;
  logic [YW-1:0] y, y_nx;
  logic [3:0]    widx;
  logic [3:0]    rd_idx;
  logic          rd_vld;
  logic [15:0]   acc;
  logic [19:0]   addr;
  logic          last_pix;

  function automatic logic is_border(input logic [XW-1:0] px, input logic [YW-1:0] py);
    return (px == '0) || (px == X_LAST) || (py == '0) || (py == Y_LAST);
  endfunction

  assign last_pix = (x == X_LAST) && (y == Y_LAST);
  assign x_nx     = (x == X_LAST) ? '0 : x + XW'(1);
  assign y_nx     = (x == X_LAST) ? y + YW'(1) : y;

  conv_addr_gen #(
    .IMG_W   (IMG_W),
    .YW      (YW),
    .SRC_BASE(SRC_BASE),
    .DST_BASE(DST_BASE)
  ) u_addr (
    .x   (x),
    .y   (y),
    .widx(widx),
    .win (state == RD),
    .addr(addr)
  );

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    sram_csn = 1'b1;
    sram_wen = 1'b1;
    sram_din = 16'h0000;
    case (state)
      IDLE: if (start) state_nx = is_border(x, y) ? BRD : RD;
      RD: begin
        busy     = 1'b1;
        sram_csn = 1'b0;
        if (widx == 4'd8) state_nx = ACC;
      end
      ACC: begin
        busy     = 1'b1;
        state_nx = WR;
      end
      WR, BRD: begin
        busy     = 1'b1;
        sram_csn = 1'b0;
        sram_wen = 1'b0;
        sram_din = (state == WR) ? acc : 16'h0000;
        if (last_pix)                 state_nx = FIN;
        else if (is_border(x_nx, y_nx)) state_nx = BRD;
        else                          state_nx = RD;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    sram_a = sram_csn ? 20'h00000 : addr;
  end

  // Read data returns one cycle late, so the tap index travels with rd_vld.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      x      <= '0;
      y      <= '0;
      widx   <= 4'd0;
      rd_idx <= 4'd0;
      rd_vld <= 1'b0;
      acc    <= 16'h0000;
    end else begin
      state  <= state_nx;
      rd_vld <= (state == RD);
      rd_idx <= widx;
      widx   <= (state == RD) ? widx + 4'd1 : 4'd0;
      if (state == WR || state == BRD) begin
        x <= last_pix ? '0 : x_nx;
        y <= last_pix ? '0 : y_nx;
      end
      if (state_nx == RD && state != RD)
        acc <= 16'h0000;
      else if (rd_vld)
        acc <= acc + (sram_dout >> win_shift(rd_idx));
    end
  end

endmodule

// File: tb/tb_conv_seq.sv
// Scoreboard bench for conv_seq on a 4x4 image: expected writes are queued at
// stimulus time and a negedge monitor pops and compares every SRAM write.
module tb_conv_seq;

  localparam int          W  = 4;
  localparam int          H  = 4;
  localparam logic [19:0] SB = 20'h00000;
  localparam logic [19:0] DB = 20'h40000;

  typedef struct {
    logic [19:0] a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, sram_csn, sram_wen;
  logic [19:0] sram_a;
  logic [15:0] sram_din;
  logic [15:0] sram_dout = 16'h0000;

  int          n_checks = 0;
  int          n_fail = 0;
  int          addr_err = 0;
  logic [15:0] src_mem [16];
  logic [15:0] dst_mem [16];
  logic [15:0] exp_img [16];
  wr_t         sb_q [$];

  always #5 clk = ~clk;

  conv_seq #(
    .IMG_W   (W),
    .IMG_H   (H),
    .SRC_BASE(SB),
    .DST_BASE(DB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .sram_csn (sram_csn),
    .sram_wen (sram_wen),
    .sram_a   (sram_a),
    .sram_din (sram_din),
    .sram_dout(sram_dout)
  );

  // Synchronous SRAM model: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (!sram_csn) begin
      if (sram_wen) begin
        if (sram_a < SB + 20'd16) sram_dout <= src_mem[sram_a[3:0]];
        else addr_err <= addr_err + 1;
      end else begin
        if (sram_a >= DB && sram_a < DB + 20'd16) dst_mem[sram_a[3:0]] <= sram_din;
        else addr_err <= addr_err + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every SRAM write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && !sram_csn && !sram_wen) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_write: got a=%0h d=%0h, expected no write", sram_a, sram_din);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        checkOutput("write_addr", 32'(sram_a), 32'(e.a));
        checkOutput("write_data", 32'(sram_din), 32'(e.d));
      end
    end
  end

  // Loads the source image and queues the hand-computed destination writes.
  task automatic applyStimulus(input logic [15:0] fill, input bit impulse,
                               input logic [15:0] e11, input logic [15:0] e12,
                               input logic [15:0] e21, input logic [15:0] e22);
    wr_t w;
    for (int i = 0; i < 16; i++) begin
      src_mem[i] = impulse ? 16'h0000 : fill;
      dst_mem[i] = 16'hDEAD;
    end
    if (impulse) src_mem[5] = 16'h0100;
    for (int py = 0; py < H; py++) begin
      for (int px = 0; px < W; px++) begin
        logic [15:0] v;
        if (px == 0 || py == 0 || px == W - 1 || py == H - 1) v = 16'h0000;
        else if (py == 1) v = (px == 1) ? e11 : e12;
        else              v = (px == 1) ? e21 : e22;
        exp_img[py * W + px] = v;
        w.a = DB + 20'(py * W + px);
        w.d = v;
        sb_q.push_back(w);
      end
    end
  endtask

  task automatic checkImage(input string tag);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("%s_dst%0d", tag, i), 32'(dst_mem[i]), 32'(exp_img[i]));
  endtask

  // Starts a job and profiles it cycle by cycle; idx 1 is the cycle after the accept edge.
  task automatic runJob(input string tag, input bit pulse);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_idx = -1;
    int rd = 0;
    int wr = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    for (int idx = 1; idx <= 75; idx++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = idx;
        checkOutput({tag, "_busy_low_at_done"}, 32'(busy), 32'd0);
      end
      if (!sram_csn && sram_wen)  rd++;
      if (!sram_csn && !sram_wen) wr++;
      start = pulse && (idx == 9 || idx == 29);
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd56);
    checkOutput({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    checkOutput({tag, "_done_cycle"}, 32'(done_idx), 32'd57);
    checkOutput({tag, "_reads"}, 32'(rd), 32'd36);
    checkOutput({tag, "_writes"}, 32'(wr), 32'd16);
    checkOutput({tag, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
    checkImage(tag);
  endtask

  initial begin
    bit seen;
    #1 rst = 1'b1;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_csn", 32'(sram_csn), 32'd1);
    checkOutput("rst_wen", 32'(sram_wen), 32'd1);
    checkOutput("rst_a", 32'(sram_a), 32'd0);
    checkOutput("rst_din", 32'(sram_din), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] constant 0010");
    applyStimulus(16'h0010, 1'b0, 16'h0010, 16'h0010, 16'h0010, 16'h0010);
    runJob("c10", 1'b0);

    $display("[TB] constant FFFF");
    applyStimulus(16'hFFFF, 1'b0, 16'hFFF7, 16'hFFF7, 16'hFFF7, 16'hFFF7);
    runJob("cff", 1'b0);

    $display("[TB] impulse");
    applyStimulus(16'h0000, 1'b1, 16'h0040, 16'h0020, 16'h0020, 16'h0010);
    runJob("imp", 1'b0);

    $display("[TB] start pulses while busy");
    applyStimulus(16'h0010, 1'b0, 16'h0010, 16'h0010, 16'h0010, 16'h0010);
    runJob("pls", 1'b1);

    $display("[TB] reset during RD of pixel (1,2)");
    applyStimulus(16'h0010, 1'b0, 16'h0010, 16'h0010, 16'h0010, 16'h0010);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (!sram_csn && !sram_wen && sram_a == DB + 20'd5) seen = 1'b1;
      else @(negedge clk);
    end
    checkOutput("mid_wr_pix5_seen", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("mid_reading", 32'({sram_csn, sram_wen}), 32'b01);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_csn", 32'(sram_csn), 32'd1);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_a", 32'(sram_a), 32'd0);
    sb_q.delete();
    repeat (2) begin
      @(negedge clk);
      checkOutput("mid_rst_hold_csn", 32'(sram_csn), 32'd1);
    end
    rst = 1'b0;
    applyStimulus(16'h0010, 1'b0, 16'h0010, 16'h0010, 16'h0010, 16'h0010);
    runJob("rrun", 1'b0);

    checkOutput("addr_range_errors", 32'(addr_err), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
